// File: rtl/bitplane_accumulator.sv
// MSB-first shift-accumulator of signed per-plane partial sums: one plane per cycle, result 1 cycle after the last
// plane in a 1-deep output buffer (in_ready = !out_valid || out_ready). BPACC_SAT_EN: clamp rather than wrap when OUT_W < ACC_W.
module bitplane_accumulator #(
  parameter int M = 16,
  parameter int N = 8,
  parameter int OUT_W = $clog2(M) + 2 + N,
  localparam int PS_W = $clog2(M) + 2,
  localparam int ACC_W = PS_W + N
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [PS_W-1:0]  in_ps,
  input  logic                    in_first,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_acc,
  output logic                    err
);

  // Counter saturates at N+1 so an overlong run can never wrap back to N.
  localparam int CNT_W = $clog2(N + 2);
  localparam logic [CNT_W-1:0] CNT_N   = CNT_W'(N);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N + 1);

  typedef enum logic {S_IDLE, S_ACC} state_t;

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] ps_ext;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0] out_acc_q, out_acc_d;
  logic signed [OUT_W-1:0] acc_red;
  logic                    err_q, err_d;
  logic                    accept;
  logic                    done;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign ps_ext   = {{N{in_ps[PS_W-1]}}, in_ps};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done    = 1'b0;
    if (accept) begin
      if (in_first) begin
        if (state_q == S_ACC) err_d = 1'b1;
        acc_d   = ps_ext;
        cnt_d   = CNT_W'(1);
        state_d = S_ACC;
      end else if (state_q == S_IDLE) begin
        err_d = 1'b1;
      end else begin
        acc_d = (acc_q <<< 1) + ps_ext;
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      end
      // Plane-count checks apply only to beats that belong to a live accumulation.
      if (in_first || state_q == S_ACC) begin
        if (in_last) begin
          done    = 1'b1;
          state_d = S_IDLE;
          if (cnt_d != CNT_N) err_d = 1'b1;
        end else if (cnt_d > CNT_N) begin
          err_d = 1'b1;
        end
      end
    end
  end

  generate
    if (OUT_W < ACC_W) begin : g_narrow
`ifdef BPACC_SAT_EN
      localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
      localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
      always_comb begin
        if (acc_d > SAT_MAX)      acc_red = SAT_MAX[OUT_W-1:0];
        else if (acc_d < SAT_MIN) acc_red = SAT_MIN[OUT_W-1:0];
        else                      acc_red = acc_d[OUT_W-1:0];
      end
`else
      assign acc_red = acc_d[OUT_W-1:0];
`endif
    end else begin : g_wide
      assign acc_red = OUT_W'(acc_d);
    end
  endgenerate

  // A new completion takes priority over draining, which keeps back-to-back results bubble-free.
  always_comb begin
    out_valid_d = out_valid_q;
    out_acc_d   = out_acc_q;
    if (done) begin
      out_valid_d = 1'b1;
      out_acc_d   = acc_red;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign err       = err_q;

endmodule
